counter_predictor_table: RTL and testbench
==========================================

# counter_predictor_table

Parametrised table of saturating counters for branch prediction. It succeeds the fixed 2-bit, 256-entry `two_bit_counter` and adds four things: configurable counter width and depth, an optional gshare history hash, a post-reset initialisation sweep, and a registered prediction with a valid flag. It sits between fetch, which issues lookups, and branch resolution, which issues updates and clears.

## Interface
- `CTR_WIDTH`, default 2: counter width in bits. Legal range is 1..4.
- `INDEX_WIDTH`, default 8: table depth is 2^INDEX_WIDTH entries.
- `HIST_WIDTH`, default 0: global history length, in the range 0..INDEX_WIDTH. A value of 0 selects pure bimodal indexing.
- `CTR_INIT`, default 2^(CTR_WIDTH-1)-1: counter value written by the reset sweep and by clear. The default is weakly not-taken.
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `reset` input, 1 bit: synchronous, active-high. Resets the whole block and starts the init sweep.
- `ready` output, 1 bit: high once the init sweep is complete.
- `get` input, 1 bit: lookup request.
- `get_index` input, INDEX_WIDTH bits: lookup index.
- `prediction` output, 1 bit: MSB of the looked-up counter. 1 means taken.
- `pred_ctr` output, CTR_WIDTH bits: full value of the looked-up counter, used as confidence.
- `pred_valid` output, 1 bit: high for one cycle, in the cycle after an accepted `get`.
- `set` input, 1 bit: update request.
- `set_index` input, INDEX_WIDTH bits: update index.
- `feedback` input, 1 bit: resolved outcome. 1 means taken.
- `clear` input, 1 bit: per-entry clear request.
- `clear_index` input, INDEX_WIDTH bits: index of the entry to clear.

## Operation
- **State machine.** Two states, INIT and RUN.
  - `reset` forces INIT and sets the sweep pointer to 0.
  - In INIT, one entry is written with CTR_INIT per cycle, and the pointer increments.
  - When the pointer reaches 2^INDEX_WIDTH-1, that entry is written and the state becomes RUN.
  - In INIT, `get`, `set` and `clear` are ignored.
- **Reset values.** `ready`=0, `prediction`=0, `pred_ctr`=0, `pred_valid`=0, history=0.
- **Hashing.** The effective index is `idx XOR {0, ghr[HIST_WIDTH-1:0]}`. It is applied to the get, set and clear indices, each using the history value of its own cycle. The history is the value before any shift in that cycle.
- **History update.** On an accepted `set`, when HIST_WIDTH>0: `ghr <= {ghr[HIST_WIDTH-2:0], feedback}`. For HIST_WIDTH=1, `ghr <= feedback`. Lookups and clears do not change the history.
- **Update arithmetic.**
  - `feedback`=1: counter becomes min(ctr+1, 2^CTR_WIDTH-1).
  - `feedback`=0: counter becomes max(ctr-1, 0).
  - The counter saturates and never wraps.
- **Clear.** Writes CTR_INIT to the hashed `clear_index`.
- **Simultaneous events, same effective index.**
  - `clear` together with `set`: clear wins. The counter becomes CTR_INIT, and the history still shifts.
  - `get` together with `set` or `clear`: the lookup returns the post-write value (write-through bypass).
- **Simultaneous events, different indices.** All operations complete independently in the same cycle.
- **Reset in RUN.** Reset restarts the sweep, and all table contents are reinitialised.

## Timing
- **Lookup latency.** `get` sampled high at edge t, with ready=1, gives `prediction`, `pred_ctr` and `pred_valid`=1 after edge t, valid for the cycle t..t+1.
- **Output hold.** `pred_valid` returns to 0 after the next edge unless `get` is held. `prediction` and `pred_ctr` hold their last value until the next accepted `get`.
- **Back-to-back gets.** Accepted every cycle; throughput is one lookup per cycle.
- **Write visibility.** A `set` or `clear` at edge t is visible to a `get` at edge t, through the bypass, and at any later edge.
- **Sweep length.** INIT lasts exactly 2^INDEX_WIDTH cycles after the last cycle with `reset` high. `ready` rises together with the final sweep write.

## Structure
- **Package `predictor_pkg`.**
  - `state_t` enum with values INIT and RUN.
  - Function `sat_update(ctr, taken)`.
  - Function `ctr_init_default(width)`.
- **Sub-module `sat_counter_next`.** Combinational next-value logic for a single counter, parametrised by CTR_WIDTH. Instantiated once for the set path.
- **Top level.** Holds the counter array, the history register, the sweep FSM, the bypass muxes and the output registers.

## Test plan
- **Reset and sweep.** Use INDEX_WIDTH=8 and assert `reset` for 1 cycle.
  - `ready` stays 0 for 256 cycles, then goes to 1.
  - A `get` issued during INIT produces no `pred_valid`.
  - A `get` to index 5 after the sweep returns `pred_ctr`=1 and `prediction`=0.
- **Saturation.** CTR_WIDTH=2, HIST_WIDTH=0.
  - Four `set` operations with feedback=1 to index 3, then `get` 3: `pred_ctr`=3, `prediction`=1.
  - Five `set` operations with feedback=0 to index 3: `pred_ctr`=0, with no wrap to 3.
- **Bypass and priority.**
  - Same-cycle `get` 7 and `set` 7 with feedback=1, from ctr=1: the next cycle shows `pred_ctr`=2.
  - Same-cycle `set` 7 and `clear` 7: the counter reads 1, which is CTR_INIT.
- **Gshare.** HIST_WIDTH=2.
  - `set` index 0 with feedback=1 gives ghr=01.
  - A `set` then applied with `set_index`=1 updates entry 0, since 1 XOR 01 = 0.
  - `get` index 1 returns entry 0's value.
- **Reset mid-operation.** Train entry 9 to 3, then assert `reset` in RUN. After the sweep, `get` 9 returns 1.
- **Width generality.** CTR_WIDTH=3, INDEX_WIDTH=4: sweep length is 16, init value is 3, and saturation is at 7 and 0.

Source files
------------

// File: rtl/predictor_pkg.sv
// ---------------------------------------------------------------------------
// predictor_pkg
//
// Shared types and helpers for the saturating-counter branch predictor table.
//   state_t          : sweep FSM states (INIT while the table is being
//                      written with the initial value, RUN for normal use)
//   MAX_CTR_WIDTH    : widest counter the helpers are sized for
//   sat_update       : next value of a saturating counter given an outcome
//   ctr_init_default : weakly-not-taken value for a given counter width
// ---------------------------------------------------------------------------
package predictor_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MAX_CTR_WIDTH = 4;

  // Counters move one step towards the resolved outcome and stick at the
  // ends of their range instead of wrapping. The helper works on the widest
  // legal counter; callers pass their real width so the ceiling is right.
  function automatic logic [MAX_CTR_WIDTH-1:0] sat_update(
    input logic [MAX_CTR_WIDTH-1:0] ctr,
    input logic                     taken,
    input int unsigned              width
  );
    logic [MAX_CTR_WIDTH-1:0] maxVal;
    maxVal = MAX_CTR_WIDTH'((32'd1 << width) - 32'd1);
    if (taken) begin
      return (ctr >= maxVal) ? ctr : ctr + MAX_CTR_WIDTH'(1);
    end
    return (ctr == '0) ? ctr : ctr - MAX_CTR_WIDTH'(1);
  endfunction

  // Largest value whose MSB is still 0, i.e. "weakly not taken".
  function automatic int unsigned ctr_init_default(input int unsigned width);
    return (32'd1 << (width - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter_next.sv
// ---------------------------------------------------------------------------
// sat_counter_next
//
// Combinational next-value logic for one saturating counter.
//   ctr_i   : current counter value
//   taken_i : resolved outcome (1 = taken, count up; 0 = count down)
//   next_o  : saturated next value
// ---------------------------------------------------------------------------
module sat_counter_next
  import predictor_pkg::*;
#(
  parameter int unsigned CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] ctr_i,
  input  logic                 taken_i,
  output logic [CTR_WIDTH-1:0] next_o
);

  // Widen to the helper's width, update, then narrow back. The saturation
  // ceiling comes from CTR_WIDTH so the upper bits never become non-zero.
  assign next_o = CTR_WIDTH'(sat_update(MAX_CTR_WIDTH'(ctr_i), taken_i, CTR_WIDTH));

endmodule

// File: rtl/counter_predictor_table.sv
// ---------------------------------------------------------------------------
// counter_predictor_table
//
// Table of 2^INDEX_WIDTH saturating counters used as a branch predictor,
// optionally gshare-indexed by a global history register.
//   clk, reset            : clock and synchronous active-high reset
//   ready                 : high once the post-reset initialisation sweep ends
//   get, get_index        : lookup request from fetch
//   prediction, pred_ctr  : MSB and full value of the looked-up counter
//   pred_valid            : one-cycle strobe after each accepted lookup
//   set, set_index,
//   feedback              : update request and resolved outcome
//   clear, clear_index    : reset a single entry to CTR_INIT
// ---------------------------------------------------------------------------
module counter_predictor_table
  import predictor_pkg::*;
#(
  parameter int unsigned CTR_WIDTH   = 2,
  parameter int unsigned INDEX_WIDTH = 8,
  parameter int unsigned HIST_WIDTH  = 0,
  parameter int unsigned CTR_INIT    = ctr_init_default(CTR_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   ready,
  input  logic                   get,
  input  logic [INDEX_WIDTH-1:0] get_index,
  output logic                   prediction,
  output logic [CTR_WIDTH-1:0]   pred_ctr,
  output logic                   pred_valid,
  input  logic                   set,
  input  logic [INDEX_WIDTH-1:0] set_index,
  input  logic                   feedback,
  input  logic                   clear,
  input  logic [INDEX_WIDTH-1:0] clear_index
);

  localparam int unsigned DEPTH = 32'd1 << INDEX_WIDTH;
  // Keep at least one history bit so the register always exists; with
  // HIST_WIDTH = 0 it simply stays at zero and the hash becomes a no-op.
  localparam int unsigned GHR_WIDTH = (HIST_WIDTH == 0) ? 1 : HIST_WIDTH;
  localparam logic [CTR_WIDTH-1:0] INIT_VAL = CTR_WIDTH'(CTR_INIT);

  state_t                 state_q;
  logic [INDEX_WIDTH-1:0] sweepPtr_q;
  logic                   ready_q;
  logic [GHR_WIDTH-1:0]   ghr_q;
  logic [GHR_WIDTH-1:0]   ghr_d;
  logic                   predValid_q;
  logic                   prediction_q;
  logic [CTR_WIDTH-1:0]   predCtr_q;

  logic [CTR_WIDTH-1:0]   ctrTable_q [DEPTH];

  logic                   running;
  logic                   getAcc;
  logic                   setAcc;
  logic                   clrAcc;
  logic [INDEX_WIDTH-1:0] hashMask;
  logic [INDEX_WIDTH-1:0] getEff;
  logic [INDEX_WIDTH-1:0] setEff;
  logic [INDEX_WIDTH-1:0] clrEff;
  logic [CTR_WIDTH-1:0]   setCur;
  logic [CTR_WIDTH-1:0]   setNext;
  logic [CTR_WIDTH-1:0]   getVal;

  // Requests are only honoured once the table holds valid contents.
  assign running = (state_q == RUN);
  assign getAcc  = get   & running;
  assign setAcc  = set   & running;
  assign clrAcc  = clear & running;

  // Gshare hash: every port uses the history as it stands at the start of
  // the cycle, so a set that shifts the history does not disturb the index
  // of a lookup or clear issued alongside it.
  assign hashMask = INDEX_WIDTH'(ghr_q);
  assign getEff   = get_index   ^ hashMask;
  assign setEff   = set_index   ^ hashMask;
  assign clrEff   = clear_index ^ hashMask;

  assign setCur = ctrTable_q[setEff];

  sat_counter_next #(
    .CTR_WIDTH (CTR_WIDTH)
  ) u_setNext (
    .ctr_i   (setCur),
    .taken_i (feedback),
    .next_o  (setNext)
  );

  // Shift the resolved outcome into the history on each accepted update.
  // Casting the concatenation down to GHR_WIDTH drops the oldest bit, which
  // also covers the single-bit history case.
  always_comb begin
    ghr_d = ghr_q;
    if ((HIST_WIDTH > 0) && setAcc) begin
      ghr_d = GHR_WIDTH'({ghr_q, feedback});
    end
  end

  // Write-through bypass so a lookup sees a same-cycle write to its entry.
  // Clear is checked first because it also wins in the table itself.
  always_comb begin
    getVal = ctrTable_q[getEff];
    if (clrAcc && (clrEff == getEff)) begin
      getVal = INIT_VAL;
    end else if (setAcc && (setEff == getEff)) begin
      getVal = setNext;
    end
  end

  // Sweep FSM, history register and registered lookup outputs. Reset parks
  // the machine in INIT at pointer 0; the last sweep write moves it to RUN
  // and raises ready in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      sweepPtr_q   <= '0;
      ready_q      <= 1'b0;
      ghr_q        <= '0;
      predValid_q  <= 1'b0;
      prediction_q <= 1'b0;
      predCtr_q    <= '0;
    end else begin
      ghr_q       <= ghr_d;
      predValid_q <= getAcc;
      if (getAcc) begin
        predCtr_q    <= getVal;
        prediction_q <= getVal[CTR_WIDTH-1];
      end
      if (state_q == INIT) begin
        sweepPtr_q <= sweepPtr_q + INDEX_WIDTH'(1);
        if (sweepPtr_q == '1) begin
          state_q <= RUN;
          ready_q <= 1'b1;
        end
      end
    end
  end

  // Counter storage. No reset here: the sweep rewrites every entry after
  // each reset. In RUN, set and clear may hit different entries in the same
  // cycle; when they hit the same one the later clear assignment wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) begin
        ctrTable_q[sweepPtr_q] <= INIT_VAL;
      end else begin
        if (setAcc) begin
          ctrTable_q[setEff] <= setNext;
        end
        if (clrAcc) begin
          ctrTable_q[clrEff] <= INIT_VAL;
        end
      end
    end
  end

  assign ready      = ready_q;
  assign prediction = prediction_q;
  assign pred_ctr   = predCtr_q;
  assign pred_valid = predValid_q;

endmodule

// File: tb/tb_counter_predictor_table.sv
// ---------------------------------------------------------------------------
// tb_counter_predictor_table
//
// Directed bench with three predictor instances:
//   dutA : 2-bit counters, 256 entries, bimodal
//   dutB : 2-bit counters, 256 entries, 2-bit gshare history
//   dutC : 3-bit counters, 16 entries, bimodal
// ---------------------------------------------------------------------------
module tb_counter_predictor_table;

  logic       clk;
  logic       rst    [3];
  logic       get    [3];
  logic [7:0] getIdx [3];
  logic       set    [3];
  logic [7:0] setIdx [3];
  logic       fb     [3];
  logic       clr    [3];
  logic [7:0] clrIdx [3];

  logic       rdyA, rdyB, rdyC;
  logic       predA, predB, predC;
  logic       pvA, pvB, pvC;
  logic [1:0] ctrA, ctrB;
  logic [2:0] ctrC;

  int checks = 0;
  int errors = 0;

  counter_predictor_table #(
    .CTR_WIDTH(2), .INDEX_WIDTH(8), .HIST_WIDTH(0)
  ) dutA (
    .clk(clk), .reset(rst[0]), .ready(rdyA),
    .get(get[0]), .get_index(getIdx[0]),
    .prediction(predA), .pred_ctr(ctrA), .pred_valid(pvA),
    .set(set[0]), .set_index(setIdx[0]), .feedback(fb[0]),
    .clear(clr[0]), .clear_index(clrIdx[0])
  );

  counter_predictor_table #(
    .CTR_WIDTH(2), .INDEX_WIDTH(8), .HIST_WIDTH(2)
  ) dutB (
    .clk(clk), .reset(rst[1]), .ready(rdyB),
    .get(get[1]), .get_index(getIdx[1]),
    .prediction(predB), .pred_ctr(ctrB), .pred_valid(pvB),
    .set(set[1]), .set_index(setIdx[1]), .feedback(fb[1]),
    .clear(clr[1]), .clear_index(clrIdx[1])
  );

  counter_predictor_table #(
    .CTR_WIDTH(3), .INDEX_WIDTH(4), .HIST_WIDTH(0)
  ) dutC (
    .clk(clk), .reset(rst[2]), .ready(rdyC),
    .get(get[2]), .get_index(getIdx[2][3:0]),
    .prediction(predC), .pred_ctr(ctrC), .pred_valid(pvC),
    .set(set[2]), .set_index(setIdx[2][3:0]), .feedback(fb[2]),
    .clear(clr[2]), .clear_index(clrIdx[2][3:0])
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int rdyOf(input int k);
    case (k)
      0:       return int'(rdyA);
      1:       return int'(rdyB);
      default: return int'(rdyC);
    endcase
  endfunction

  function automatic int pvOf(input int k);
    case (k)
      0:       return int'(pvA);
      1:       return int'(pvB);
      default: return int'(pvC);
    endcase
  endfunction

  function automatic int predOf(input int k);
    case (k)
      0:       return int'(predA);
      1:       return int'(predB);
      default: return int'(predC);
    endcase
  endfunction

  function automatic int ctrOf(input int k);
    case (k)
      0:       return int'(ctrA);
      1:       return int'(ctrB);
      default: return int'(ctrC);
    endcase
  endfunction

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one cycle of requests to instance k, then drop them.
  task automatic applyStimulus(input int k,
                               input logic g, input logic [7:0] gi,
                               input logic s, input logic [7:0] si, input logic f,
                               input logic c, input logic [7:0] ci);
    get[k] = g; getIdx[k] = gi;
    set[k] = s; setIdx[k] = si; fb[k] = f;
    clr[k] = c; clrIdx[k] = ci;
    tick();
    get[k] = 1'b0;
    set[k] = 1'b0;
    clr[k] = 1'b0;
  endtask

  task automatic doGet(input int k, input logic [7:0] i);
    applyStimulus(k, 1'b1, i, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic doSet(input int k, input logic [7:0] i, input logic f);
    applyStimulus(k, 1'b0, 8'd0, 1'b1, i, f, 1'b0, 8'd0);
  endtask

  task automatic doClr(input int k, input logic [7:0] i);
    applyStimulus(k, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, i);
  endtask

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkLookup(input int k, input string tag, input int expCtr, input int expPred);
    checkOutput({tag, ".valid"}, pvOf(k), 1);
    checkOutput({tag, ".ctr"}, ctrOf(k), expCtr);
    checkOutput({tag, ".pred"}, predOf(k), expPred);
  endtask

  // Bounded wait for ready; n = cycles after the reset edge, 0 on timeout.
  task automatic waitReady(input int k, output int n);
    n = 0;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (rdyOf(k) != 0) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int readyAt [3];
    int sawValid;
    int n;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      get[k] = 1'b0; getIdx[k] = 8'd0;
      set[k] = 1'b0; setIdx[k] = 8'd0; fb[k] = 1'b0;
      clr[k] = 1'b0; clrIdx[k] = 8'd0;
      readyAt[k] = 0;
    end
    sawValid = 0;

    // One reset cycle for everyone, then look at the reset values.
    tick();
    checkOutput("rstA.ready", rdyOf(0), 0);
    checkOutput("rstA.valid", pvOf(0), 0);
    checkOutput("rstA.ctr", ctrOf(0), 0);
    checkOutput("rstA.pred", predOf(0), 0);
    checkOutput("rstC.ready", rdyOf(2), 0);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Sweep lengths; A holds a lookup during INIT which must be ignored.
    get[0] = 1'b1;
    getIdx[0] = 8'd5;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (pvOf(0) != 0) sawValid = 1;
      for (int k = 0; k < 3; k++) begin
        if (readyAt[k] == 0 && rdyOf(k) != 0) readyAt[k] = i;
      end
      if (readyAt[0] != 0 && readyAt[1] != 0 && readyAt[2] != 0) break;
    end
    get[0] = 1'b0;
    checkOutput("sweepA.len", readyAt[0], 256);
    checkOutput("sweepB.len", readyAt[1], 256);
    checkOutput("sweepC.len", readyAt[2], 16);
    checkOutput("initGetIgnored", sawValid, 0);

    // Freshly initialised entry, then output hold.
    doGet(0, 8'd5);
    checkLookup(0, "getA5", 1, 0);
    tick();
    checkOutput("holdA.valid", pvOf(0), 0);
    checkOutput("holdA.ctr", ctrOf(0), 1);

    // Saturation at the top and bottom.
    for (int i = 0; i < 4; i++) doSet(0, 8'd3, 1'b1);
    doGet(0, 8'd3);
    checkLookup(0, "satHigh", 3, 1);
    for (int i = 0; i < 5; i++) doSet(0, 8'd3, 1'b0);
    doGet(0, 8'd3);
    checkLookup(0, "satLow", 0, 0);

    // Bypass and clear priority on entry 7.
    applyStimulus(0, 1'b1, 8'd7, 1'b1, 8'd7, 1'b1, 1'b0, 8'd0);
    checkLookup(0, "bypassSet", 2, 1);
    applyStimulus(0, 1'b0, 8'd0, 1'b1, 8'd7, 1'b1, 1'b1, 8'd7);
    doGet(0, 8'd7);
    checkLookup(0, "clearWins", 1, 0);
    applyStimulus(0, 1'b1, 8'd7, 1'b1, 8'd7, 1'b0, 1'b0, 8'd0);
    checkLookup(0, "bypassDec", 0, 0);
    applyStimulus(0, 1'b1, 8'd7, 1'b0, 8'd0, 1'b0, 1'b1, 8'd7);
    checkLookup(0, "bypassClr", 1, 0);

    // Independent operations on different entries in one cycle.
    doSet(0, 8'd11, 1'b1);
    applyStimulus(0, 1'b1, 8'd12, 1'b1, 8'd10, 1'b1, 1'b1, 8'd11);
    checkLookup(0, "indepGet12", 1, 0);
    doGet(0, 8'd10);
    checkLookup(0, "indepSet10", 2, 1);
    doGet(0, 8'd11);
    checkLookup(0, "indepClr11", 1, 0);

    // Gshare on dutB: history 00 -> 01 -> 11 -> 10.
    doSet(1, 8'd0, 1'b1);
    doGet(1, 8'd1);
    checkLookup(1, "gsGet1", 2, 1);
    doGet(1, 8'd0);
    checkLookup(1, "gsGet0", 1, 0);
    doSet(1, 8'd1, 1'b1);
    doGet(1, 8'd3);
    checkLookup(1, "gsGet3", 3, 1);
    applyStimulus(1, 1'b1, 8'd3, 1'b1, 8'd3, 1'b0, 1'b0, 8'd0);
    checkLookup(1, "gsBypass", 2, 1);
    doGet(1, 8'd2);
    checkLookup(1, "gsGet2", 2, 1);
    doClr(1, 8'd2);
    doGet(1, 8'd2);
    checkLookup(1, "gsClr", 1, 0);

    // Wider counters on the small table.
    doGet(2, 8'd4);
    checkLookup(2, "cInit", 3, 0);
    doSet(2, 8'd4, 1'b1);
    doGet(2, 8'd4);
    checkLookup(2, "cStep", 4, 1);
    for (int i = 0; i < 4; i++) doSet(2, 8'd4, 1'b1);
    doGet(2, 8'd4);
    checkLookup(2, "cSatHigh", 7, 1);
    for (int i = 0; i < 8; i++) doSet(2, 8'd4, 1'b0);
    doGet(2, 8'd4);
    checkLookup(2, "cSatLow", 0, 0);
    doClr(2, 8'd4);
    doGet(2, 8'd4);
    checkLookup(2, "cClr", 3, 0);

    // Reset during RUN must re-sweep the whole table.
    doSet(0, 8'd9, 1'b1);
    doSet(0, 8'd9, 1'b1);
    doGet(0, 8'd9);
    checkLookup(0, "train9", 3, 1);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    checkOutput("midRst.ready", rdyOf(0), 0);
    checkOutput("midRst.ctr", ctrOf(0), 0);
    checkOutput("midRst.pred", predOf(0), 0);
    waitReady(0, n);
    checkOutput("midRst.len", n, 256);
    doGet(0, 8'd9);
    checkLookup(0, "afterRst9", 1, 0);
    doGet(0, 8'd3);
    checkLookup(0, "afterRst3", 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
